mem_dump_reader: RTL

Read-back engine for the processor's 7-bit-addressed, 32-bit data memory; it is the counterpart to the bench-side writer that preloads memory. On a start pulse it walks an address range, issues one read per word, and streams each word with its address to a consumer over a valid/ready handshake. Result checking, waveform dumps and a future UART debug port all consume this stream.

---
 rtl/mem_dump_pkg.sv | 17 +
 rtl/mem_dump_reader_if.sv | 29 ++
 rtl/mem_dump_addr_gen.sv | 32 +++
 rtl/mem_dump_reader.sv | 131 +++++++++++++
 4 files changed

// File: rtl/mem_dump_pkg.sv
// Shared types and default widths for the memory read-back engine.
// Widths match the processor's 7-bit-addressed, 32-bit data memory.
package mem_dump_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_PRESENT,
        ST_SUM,
        ST_FINISH
    } state_t;

endpackage

// File: rtl/mem_dump_reader_if.sv
// Memory read port plus the outgoing beat stream of the dump reader.
// master = reader side, slave = memory/consumer side.
interface mem_dump_reader_if #(
    parameter int ADDR_W = mem_dump_pkg::ADDR_W_DEF,
    parameter int DATA_W = mem_dump_pkg::DATA_W_DEF
) ();
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    modport master (
        output mem_rd_en, mem_addr,
        input  mem_rdata,
        output out_valid, out_data, out_addr, out_last,
        input  out_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr,
        output mem_rdata,
        input  out_valid, out_data, out_addr, out_last,
        output out_ready
    );
endinterface

// File: rtl/mem_dump_addr_gen.sv
// Holds the current/final dump address, steps with wrap-around and flags the end.
module mem_dump_addr_gen #(
    parameter int ADDR_W = mem_dump_pkg::ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] cur,
    output logic [ADDR_W-1:0] nxt,
    output logic              at_end
);
    logic [ADDR_W-1:0] end_addr;

    // Natural overflow of the ADDR_W-bit add gives the ring wrap.
    assign nxt    = cur + ADDR_W'(1);
    assign at_end = (cur == end_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur      <= '0;
            end_addr <= '0;
        end else if (load) begin
            cur      <= first_addr;
            end_addr <= last_addr;
        end else if (advance) begin
            cur <= nxt;
        end
    end
endmodule

// File: rtl/mem_dump_reader.sv
// Walks a wrapping address range, reads each word and streams (addr,data) beats.
// Optional trailing checksum beat when MEM_DUMP_CHECKSUM_EN is defined.
module mem_dump_reader
    import mem_dump_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              busy,
    output logic              done,
    mem_dump_reader_if.master bus
);
    state_t            state;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] nxt;
    logic              at_end;
    logic              load;
    logic              advance;
    logic              hs;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] acc;
`endif

    // hs only feeds registers, so out_ready never reaches outputs combinationally.
    assign hs      = bus.out_valid && bus.out_ready;
    assign load    = (state == ST_IDLE) && start;
    assign advance = (state == ST_PRESENT) && hs && !at_end;

    mem_dump_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .advance    (advance),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .cur        (cur),
        .nxt        (nxt),
        .at_end     (at_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            bus.mem_rd_en <= 1'b0;
            bus.mem_addr  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_addr  <= '0;
            bus.out_last  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
            acc           <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bus.mem_rd_en <= 1'b1;
                        bus.mem_addr  <= first_addr;
                        busy          <= 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
                        acc           <= '0;
`endif
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    bus.mem_rd_en <= 1'b0;
                    state         <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    bus.out_data  <= bus.mem_rdata[DATA_W-1:0];
                    bus.out_addr  <= cur;
`ifdef MEM_DUMP_CHECKSUM_EN
                    bus.out_last  <= 1'b0;
`else
                    bus.out_last  <= at_end;
`endif
                    bus.out_valid <= 1'b1;
                    state         <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (hs) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                        acc <= acc + bus.out_data;
`endif
                        if (!at_end) begin
                            bus.out_valid <= 1'b0;
                            bus.mem_rd_en <= 1'b1;
                            bus.mem_addr  <= nxt;
                            state         <= ST_ISSUE;
                        end else begin
`ifdef MEM_DUMP_CHECKSUM_EN
                            // Stay valid; out_addr already holds the end address.
                            bus.out_data <= acc + bus.out_data;
                            bus.out_last <= 1'b1;
                            state        <= ST_SUM;
`else
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            done          <= 1'b1;
                            busy          <= 1'b0;
                            state         <= ST_FINISH;
`endif
                        end
                    end
                end
                ST_SUM: begin
                    if (hs) begin
                        bus.out_valid <= 1'b0;
                        bus.out_last  <= 1'b0;
                        done          <= 1'b1;
                        busy          <= 1'b0;
                        state         <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
